nand_apb_regs: RTL and testbench
================================

Name: nand_apb_regs

Overview:
- APB slave register file sitting directly upstream of the NAND flash command FSM.
- Software programs the command bytes, 5 address bytes, transfer length and operation type, then writes GO.
- The block presents a stable operation descriptor and a valid/ready start handshake to the FSM, then tracks completion.
- It also captures the flash status byte, enforces a completion timeout, and raises an interrupt.

Parameters:
- ID_VALUE, 32'h4E46_0001, constant returned by the ID register.
- TIMEOUT_CYC, 20'd1000000, P_clk cycles allowed from handshake acceptance to C_Done before abort; 0 disables the timeout.

Ports:
- P_clk  in  1  APB/system clock.
- P_nrst  in  1  asynchronous active-low reset.
- P_sel  in  1  APB select.
- P_enable  in  1  APB enable (access phase).
- P_write  in  1  1 = write, 0 = read.
- P_addr  in  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
- P_wdata  in  32  write data.
- P_rdata  out  32  read data.
- P_ready  out  1  always 1 (zero wait states).
- P_slverr  out  1  error response, valid in the access phase.
- C_Cmd  out  16  {cmd1, cmd0} to the FSM.
- C_Addr  out  40  {addr4..addr0} to the FSM.
- C_Length  out  8  transfer byte count.
- C_Op  out  2  00 read, 01 program, 10 erase, 11 reset.
- C_Start  out  1  operation request (valid).
- C_Ready  in  1  FSM accepts the request.
- C_Done  in  1  one-cycle pulse, operation complete.
- C_Status  in  8  flash status byte, sampled when C_Done is high.
- C_Abort  out  1  one-cycle pulse on timeout.
- IRQ  out  1  level interrupt.

Behaviour:
- Reset: P_nrst asynchronous, active-low; clock P_clk.
  - All registers and outputs reset to 0, except P_ready = 1.
  - C_Start = 0, C_Abort = 0, IRQ = 0. State = IDLE.
- Register map:
  - 0x00 CMD: [7:0] cmd0, [15:8] cmd1. RW.
  - 0x04 ADDR_LO: addr3..addr0. RW.
  - 0x08 ADDR_HI: [7:0] addr4. RW.
  - 0x0C LEN: [7:0]. RW.
  - 0x10 CTRL: [0] GO (write-1 to launch, reads 0), [2:1] OP, [3] IE. RW.
  - 0x14 STATUS:
    - [0] BUSY RO.
    - [1] DONE W1C.
    - [2] ERR W1C.
    - [3] TMO W1C.
    - [15:8] captured C_Status RO.
  - 0x18 ID: RO, returns ID_VALUE.
  - 0x1C: unmapped.
- APB timing:
  - A write takes effect on the P_clk edge where P_sel & P_enable & P_write; no effect in the setup phase.
  - P_rdata is combinational from P_addr during the access phase; 0 for unmapped addresses.
  - Unused register bits read 0.
- P_slverr = 1 in the access phase for any of:
  - an unmapped address;
  - a write to ID or to the STATUS RO field alone (a W1C write to STATUS is legal);
  - a write to CMD/ADDR/LEN/CTRL while BUSY. The register is unchanged; a GO write while BUSY also sets ERR.
- State machine:
  - IDLE: a CTRL write with GO=1 latches OP and IE from that same write, sets BUSY, and moves to REQ. The next cycle C_Start = 1.
  - REQ: C_Start is held at 1 and C_Cmd/C_Addr/C_Length/C_Op are held stable. When C_Start & C_Ready on a clock edge, C_Start = 0 next cycle, the timeout counter clears, and the state moves to WAIT.
  - WAIT: the counter increments each cycle.
    - On C_Done: capture C_Status into STATUS[15:8], set DONE, clear BUSY, go to IDLE.
    - If the count reaches TIMEOUT_CYC (and TIMEOUT_CYC ≠ 0) before C_Done: C_Abort is pulsed for 1 cycle, TMO and ERR are set, BUSY clears, go to IDLE.
    - If C_Done arrives in the same cycle the count reaches TIMEOUT_CYC, C_Done wins: DONE is set, no abort.
  - C_Done seen in IDLE or REQ is ignored and sets nothing.
  - Back-to-back: GO written in the cycle after return to IDLE is legal.
- W1C rule: if a hardware set and a software clear of the same bit coincide, the set wins.
- IRQ = IE & (DONE | ERR), registered. It updates one cycle after the flag changes.
- Latency: C_Start rises 1 cycle after the GO write edge. A STATUS read in the cycle after the C_Done edge shows DONE = 1.
- Reset mid-operation: async return to IDLE with all registers cleared. C_Start and C_Abort drop immediately without a clock.
- The C_* descriptor outputs are driven directly from registers; they change only through legal writes while not BUSY.

Test Plan:
- Reset, then read all addresses → 0 everywhere except ID = 32'h4E46_0001; 0x1C read → P_rdata = 0, P_slverr = 1.
- Program CMD = 16'h3000, ADDR_LO = 32'h04030201, ADDR_HI = 8'h05, LEN = 8'd16, CTRL = 32'h1 (OP = 00) with C_Ready held low 3 cycles then high → C_Start high 4 cycles; C_Addr = 40'h0504030201, C_Cmd = 16'h3000 stable throughout; BUSY = 1.
- In WAIT, pulse C_Done with C_Status = 8'hE0 and IE = 1 → STATUS = 32'h0000_E002; IRQ = 1 next cycle; W1C write 32'h2 → DONE = 0, IRQ = 0.
- While BUSY, write LEN = 8'd99 and GO = 1 → P_slverr = 1 for both writes; LEN stays 16; ERR = 1; operation still completes normally.
- TIMEOUT_CYC = 20 with no C_Done → C_Abort pulses exactly 20 cycles after the handshake; STATUS[3:0] = 4'b1100; BUSY = 0. Repeat with C_Done on cycle 20 → DONE = 1, no abort.
- Deassert P_nrst while in REQ → C_Start = 0 asynchronously; after release all registers read 0 and a new GO launches normally.

Source files
------------

// File: rtl/nand_apb_regs.sv
// APB register file feeding the NAND command FSM: holds the operation descriptor,
// runs the start handshake, tracks completion/timeout and raises the interrupt.
module nand_apb_regs #(
  parameter logic [31:0] ID_VALUE    = 32'h4E46_0001,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic        P_clk,
  input  logic        P_nrst,
  input  logic        P_sel,
  input  logic        P_enable,
  input  logic        P_write,
  input  logic [4:0]  P_addr,
  input  logic [31:0] P_wdata,
  output logic [31:0] P_rdata,
  output logic        P_ready,
  output logic        P_slverr,
  output logic [15:0] C_Cmd,
  output logic [39:0] C_Addr,
  output logic [7:0]  C_Length,
  output logic [1:0]  C_Op,
  output logic        C_Start,
  input  logic        C_Ready,
  input  logic        C_Done,
  input  logic [7:0]  C_Status,
  output logic        C_Abort,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [15:0] cmd;
  logic [39:0] addr;
  logic [7:0]  len;
  logic [1:0]  op;
  logic        ie;
  logic        done, err, tmo;
  logic [7:0]  stat;
  logic [19:0] cnt, cnt_nxt;
  logic        abort, irq;

  logic [2:0]  idx;
  logic        acc, wr, busy, ro_err, busy_err, wr_ok;
  logic        go_launch, go_busy, hs, done_set, tmo_hit, sts_clr;
  logic        unused_addr_lsb;

  assign idx             = P_addr[4:2];
  assign unused_addr_lsb = ^P_addr[1:0];
  assign acc             = P_sel & P_enable;
  assign wr              = acc & P_write;
  assign busy            = (state != S_IDLE);
  assign cnt_nxt         = cnt + 20'd1;

  always_comb begin
    ro_err   = (idx == 3'd6) || ((idx == 3'd5) && (P_wdata[3:1] == 3'b000));
    busy_err = busy && (idx <= 3'd4);
  end

  assign P_ready   = 1'b1;
  assign P_slverr  = acc & ((idx == 3'd7) | (P_write & (ro_err | busy_err)));
  assign wr_ok     = wr & ~P_slverr;
  assign go_launch = wr_ok & (idx == 3'd4) & P_wdata[0];
  assign go_busy   = wr & busy & (idx == 3'd4) & P_wdata[0];
  assign sts_clr   = wr_ok & (idx == 3'd5);
  assign hs        = (state == S_REQ) & C_Ready;
  assign done_set  = (state == S_WAIT) & C_Done;
  // C_Done on the terminal count takes priority over the abort
  assign tmo_hit   = (state == S_WAIT) & ~C_Done & (TIMEOUT_CYC != '0) &
                     (cnt_nxt == TIMEOUT_CYC);

  always_ff @(posedge P_clk or negedge P_nrst) begin
    if (!P_nrst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_launch) state_nxt = S_REQ;
      S_REQ:   if (hs) state_nxt = S_WAIT;
      S_WAIT:  if (done_set || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge P_clk or negedge P_nrst) begin
    if (!P_nrst) begin
      cmd   <= '0;
      addr  <= '0;
      len   <= '0;
      op    <= '0;
      ie    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      tmo   <= 1'b0;
      stat  <= '0;
      cnt   <= '0;
      abort <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (idx)
          3'd0: cmd        <= P_wdata[15:0];
          3'd1: addr[31:0] <= P_wdata;
          3'd2: addr[39:32] <= P_wdata[7:0];
          3'd3: len        <= P_wdata[7:0];
          3'd4: begin
            op <= P_wdata[2:1];
            ie <= P_wdata[3];
          end
          default: ;
        endcase
      end
      if (hs)                     cnt <= '0;
      else if (state == S_WAIT)   cnt <= cnt_nxt;
      if (done_set) stat <= C_Status;
      // hardware set beats a coincident software clear
      done  <= done_set | (done & ~(sts_clr & P_wdata[1]));
      err   <= tmo_hit | go_busy | (err & ~(sts_clr & P_wdata[2]));
      tmo   <= tmo_hit | (tmo & ~(sts_clr & P_wdata[3]));
      abort <= tmo_hit;
      irq   <= ie & (done | err);
    end
  end

  always_comb begin
    P_rdata = '0;
    if (acc && !P_write) begin
      case (idx)
        3'd0:    P_rdata = {16'h0, cmd};
        3'd1:    P_rdata = addr[31:0];
        3'd2:    P_rdata = {24'h0, addr[39:32]};
        3'd3:    P_rdata = {24'h0, len};
        3'd4:    P_rdata = {28'h0, ie, op, 1'b0};
        3'd5:    P_rdata = {16'h0, stat, 4'h0, tmo, err, done, busy};
        3'd6:    P_rdata = ID_VALUE;
        default: P_rdata = '0;
      endcase
    end
  end

  assign C_Cmd    = cmd;
  assign C_Addr   = addr;
  assign C_Length = len;
  assign C_Op     = op;
  assign C_Start  = (state == S_REQ);
  assign C_Abort  = abort;
  assign IRQ      = irq;

endmodule

// File: tb/tb_nand_apb_regs.sv
// Scoreboarded bench for nand_apb_regs: APB accesses queue their expected response,
// a negedge monitor checks each access phase; handshake/timeout/IRQ checked inline.
module tb_nand_apb_regs;

  logic        P_clk = 1'b0;
  logic        P_nrst = 1'b0;
  logic        P_sel = 1'b0, P_enable = 1'b0, P_write = 1'b0;
  logic [4:0]  P_addr = '0;
  logic [31:0] P_wdata = '0;
  logic [31:0] P_rdata;
  logic        P_ready, P_slverr;
  logic [15:0] C_Cmd;
  logic [39:0] C_Addr;
  logic [7:0]  C_Length;
  logic [1:0]  C_Op;
  logic        C_Start, C_Abort, IRQ;
  logic        C_Ready = 1'b0, C_Done = 1'b0;
  logic [7:0]  C_Status = '0;

  nand_apb_regs #(.TIMEOUT_CYC(20'd20)) dut (
    .P_clk(P_clk), .P_nrst(P_nrst), .P_sel(P_sel), .P_enable(P_enable),
    .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_rdata(P_rdata),
    .P_ready(P_ready), .P_slverr(P_slverr), .C_Cmd(C_Cmd), .C_Addr(C_Addr),
    .C_Length(C_Length), .C_Op(C_Op), .C_Start(C_Start), .C_Ready(C_Ready),
    .C_Done(C_Done), .C_Status(C_Status), .C_Abort(C_Abort), .IRQ(IRQ)
  );

  always #5 P_clk = ~P_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    bit          is_read;
    string       name;
  } exp_t;
  exp_t sb[$];

  // reference model: architectural register contents
  logic [15:0] m_cmd;
  logic [39:0] m_addr;
  logic [7:0]  m_len, m_stat;
  logic [1:0]  m_op;
  logic        m_ie, m_busy, m_done, m_err, m_tmo;

  task automatic m_reset();
    m_cmd = '0; m_addr = '0; m_len = '0; m_stat = '0; m_op = '0;
    m_ie = 0; m_busy = 0; m_done = 0; m_err = 0; m_tmo = 0;
  endtask

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return {16'h0, m_cmd};
      1: return m_addr[31:0];
      2: return {24'h0, m_addr[39:32]};
      3: return {24'h0, m_len};
      4: return {28'h0, m_ie, m_op, 1'b0};
      5: return {16'h0, m_stat, 4'h0, m_tmo, m_err, m_done, m_busy};
      6: return 32'h4E46_0001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_slverr(input int idx, input bit wr, input logic [31:0] wd);
    if (idx == 7) return 1'b1;
    if (!wr) return 1'b0;
    if (idx == 6) return 1'b1;
    if (idx == 5) return (wd[3:1] == 3'b000);
    return m_busy;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge P_clk) begin : monitor
    exp_t e;
    if (P_sel && P_enable) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=access expected=none at %0t", $time);
      end else begin
        e = sb.pop_front();
        check({e.name, "_slverr"}, P_slverr, e.slverr);
        check({e.name, "_ready"}, P_ready, 1'b1);
        if (e.is_read) check({e.name, "_rdata"}, P_rdata, e.rdata);
      end
    end
  end

  task automatic apb_access(input int idx, input bit wr, input logic [31:0] wd);
    logic [2:0] i3;
    i3 = idx[2:0];
    @(posedge P_clk); #1;
    P_sel = 1; P_enable = 0; P_write = wr; P_wdata = wd;
    P_addr = {i3, 2'($urandom_range(0, 3))};
    @(posedge P_clk); #1;
    P_enable = 1;
    @(posedge P_clk); #1;
    P_sel = 0; P_enable = 0; P_write = 0;
  endtask

  task automatic apb_read(input int idx);
    exp_t e;
    e.rdata = m_read(idx); e.slverr = m_slverr(idx, 0, '0);
    e.is_read = 1; e.name = $sformatf("rd%0d", idx);
    sb.push_back(e);
    apb_access(idx, 0, '0);
  endtask

  task automatic apb_write(input int idx, input logic [31:0] wd);
    exp_t e;
    logic bad;
    bad = m_slverr(idx, 1, wd);
    e.rdata = '0; e.slverr = bad; e.is_read = 0; e.name = $sformatf("wr%0d", idx);
    sb.push_back(e);
    apb_access(idx, 1, wd);
    if (!bad) begin
      case (idx)
        0: m_cmd = wd[15:0];
        1: m_addr[31:0] = wd;
        2: m_addr[39:32] = wd[7:0];
        3: m_len = wd[7:0];
        4: begin m_op = wd[2:1]; m_ie = wd[3]; if (wd[0]) m_busy = 1; end
        5: begin
          if (wd[1]) m_done = 0;
          if (wd[2]) m_err = 0;
          if (wd[3]) m_tmo = 0;
        end
        default: ;
      endcase
    end else if (idx == 4 && wd[0] && m_busy) begin
      m_err = 1;
    end
  endtask

  task automatic chk_desc();
    check("c_cmd", C_Cmd, m_cmd);
    check("c_addr", C_Addr, m_addr);
    check("c_len", C_Length, m_len);
    check("c_op", C_Op, m_op);
  endtask

  task automatic check_irq();
    @(posedge P_clk); #1;
    check("irq", IRQ, m_ie & (m_done | m_err));
  endtask

  // GO, then hold C_Ready low for rdy cycles before the handshake
  task automatic start_op(input logic [1:0] op, input logic ie, input int rdy);
    apb_write(4, {28'h0, ie, op, 1'b1});
    repeat (rdy) begin
      check("start_hi", C_Start, 1'b1);
      chk_desc();
      @(posedge P_clk); #1;
    end
    check("start_hi", C_Start, 1'b1);
    chk_desc();
    C_Ready = 1;
    @(posedge P_clk); #1;
    C_Ready = 0;
    check("start_lo", C_Start, 1'b0);
  endtask

  task automatic finish_op(input int dly, input logic [7:0] st);
    repeat (dly - 1) begin @(posedge P_clk); #1; end
    C_Done = 1; C_Status = st;
    @(posedge P_clk); #1;
    C_Done = 0;
    m_stat = st; m_done = 1; m_busy = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    m_reset();
    #23 P_nrst = 1;
    check("rst_start", C_Start, 1'b0);
    check("rst_abort", C_Abort, 1'b0);
    check("rst_irq", IRQ, 1'b0);
    check("rst_ready", P_ready, 1'b1);
    for (int i = 0; i < 8; i++) apb_read(i);

    // directed launch with delayed ready, then completion and IRQ
    apb_write(0, 32'h0000_3000);
    apb_write(1, 32'h0403_0201);
    apb_write(2, 32'h0000_0005);
    apb_write(3, 32'd16);
    start_op(2'b00, 1'b1, 3);
    check("addr_fixed", C_Addr, 40'h05_0403_0201);
    check("cmd_fixed", C_Cmd, 16'h3000);
    apb_read(5);
    finish_op(3, 8'hE0);
    check("irq_lag", IRQ, 1'b0);
    check_irq();
    apb_read(5);
    apb_write(5, 32'h2);
    check_irq();

    // illegal writes while busy
    start_op(2'b01, 1'b1, 0);
    apb_write(3, 32'd99);
    apb_write(4, 32'h1);
    apb_read(3);
    finish_op(2, 8'h5A);
    apb_read(5);
    check_irq();
    apb_write(5, 32'hE);

    // timeout with no C_Done
    start_op(2'b10, 1'b0, 1);
    for (int i = 1; i < 20; i++) begin
      @(posedge P_clk); #1;
      check("abort_early", C_Abort, 1'b0);
    end
    @(posedge P_clk); #1;
    check("abort_pulse", C_Abort, 1'b1);
    m_tmo = 1; m_err = 1; m_busy = 0;
    @(posedge P_clk); #1;
    check("abort_end", C_Abort, 1'b0);
    apb_read(5);
    apb_write(5, 32'hE);

    // C_Done on the terminal cycle wins
    start_op(2'b11, 1'b0, 0);
    finish_op(20, 8'hC3);
    check("no_abort0", C_Abort, 1'b0);
    @(posedge P_clk); #1;
    check("no_abort1", C_Abort, 1'b0);
    apb_read(5);

    // randomized operations
    for (int n = 0; n < 10; n++) begin
      apb_write(0, $urandom);
      apb_write(1, $urandom);
      apb_write(2, $urandom);
      apb_write(3, $urandom);
      apb_write(4, {$urandom} & 32'hFFFF_FFFE);
      apb_write(6, $urandom);
      apb_read($urandom_range(0, 7));
      start_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      apb_read(5);
      finish_op($urandom_range(1, 12), 8'($urandom));
      apb_read(5);
      check_irq();
      apb_write(5, $urandom);
      apb_read(5);
      check_irq();
    end

    // reset while requesting
    apb_write(4, 32'h1);
    check("req_start", C_Start, 1'b1);
    P_nrst = 0;
    #2;
    check("async_start", C_Start, 1'b0);
    check("async_abort", C_Abort, 1'b0);
    m_reset();
    #10 P_nrst = 1;
    for (int i = 0; i < 8; i++) apb_read(i);
    @(posedge P_clk); #1;
    C_Done = 1; C_Status = 8'hFF;
    @(posedge P_clk); #1;
    C_Done = 0;
    apb_read(5);
    apb_write(3, 32'd7);
    start_op(2'b01, 1'b1, 2);
    finish_op(4, 8'h81);
    apb_read(5);
    check_irq();

    repeat (3) @(posedge P_clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
